reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Combines NUM_INPUT_RESETS active-low reset requests plus a synchronous software request into one reset event.
//  Releases NUM_STAGES active-low output resets in a fixed order with programmable spacing, e.g. PHY, then MAC,
//  then user logic. Guarantees a minimum assertion time per event, reports completion and counts events.
//  Sits in each clock domain's top level, next to the clock generator.
// PARAMETERS
//  NUM_INPUT_RESETS  1   number of active-low reset request inputs
//  NUM_STAGES        4   number of sequenced output resets; minimum 1
//  SYNC_DEPTH        2   input synchronizer length in flops; minimum 2
//  MIN_HOLD_CYCLES   16  cycles all requests must stay clean before stage 0 releases; minimum 1
//  STAGE_GAP_CYCLES  8   cycles between consecutive stage releases; minimum 1
//  SW_RST_ENABLE     1   0 = i_sw_rst_req is ignored
//  EVENT_CNT_WIDTH   8   width of o_event_cnt
// PORTS
//  i_clk          in   1                  domain clock
//  i_rst          in   1                  asynchronous, active-high block reset
//  i_rstn_array   in   NUM_INPUT_RESETS   asynchronous active-low reset requests
//  i_sw_rst_req   in   1                  synchronous active-high software reset request
//  o_rstn         out  NUM_STAGES         sequenced active-low resets; bit 0 releases first
//  o_ready        out  1                  high when every stage is released
//  o_busy         out  1                  high in HOLD or SEQ
//  o_event_cnt    out  EVENT_CNT_WIDTH    saturating count of completed sequences that were later interrupted by a new reset event
// BEHAVIOUR
//  - One clock. i_rst is asynchronous and active-high.
//  - While i_rst=1: o_rstn=0, o_ready=0, o_busy=1, o_event_cnt=0, state=HOLD, and every synchronizer flop=0.
//  - All outputs are registered. No combinational path from input to output.
//  - Input synchronizer, one per bit:
//    - A low on i_rstn_array[i] asynchronously clears the chain.
//    - The chain shifts in 1 per edge, so deassertion is seen SYNC_DEPTH edges later.
//    - A low pulse shorter than one clock is still captured.
//  - trig = any synced bit low, OR (SW_RST_ENABLE and i_sw_rst_req).
//  - FSM states: HOLD, SEQ, DONE.
//  - HOLD:
//    - o_rstn=0, o_ready=0.
//    - hold_cnt is cleared on any cycle with trig=1, and increments otherwise.
//    - When hold_cnt reaches MIN_HOLD_CYCLES-1 with trig=0, the next edge enters SEQ, sets o_rstn[0]=1 and clears gap_cnt.
//  - SEQ:
//    - gap_cnt counts up to STAGE_GAP_CYCLES-1.
//    - At that edge, o_rstn[stage+1]=1, stage increments, and gap_cnt clears.
//    - The edge that releases stage NUM_STAGES-1 also enters DONE and sets o_ready=1.
//    - If NUM_STAGES=1, HOLD goes directly to DONE. o_rstn[0] and o_ready rise on the same edge.
//  - DONE: holds. o_ready=1, o_busy=0.
//  - trig=1 in SEQ or DONE: the next edge enters HOLD with o_rstn=0, o_ready=0 and hold_cnt=0.
//    - From DONE only, o_event_cnt increments, saturating at all-ones.
//  - Latency:
//    - input fall -> o_rstn all 0 at the first rising edge after the fall.
//    - i_sw_rst_req sampled high at edge e -> o_rstn all 0 after edge e.
//    - clean inputs -> o_rstn[0] rises after SYNC_DEPTH+MIN_HOLD_CYCLES edges.
//    - o_rstn[k] rises k*STAGE_GAP_CYCLES edges after o_rstn[0].
//  - Each bit of o_rstn, once low, stays low until its scheduled release. A released stage never re-releases out of order.
//  - trig=1 held continuously keeps the block in HOLD indefinitely.
//  - Counter widths are $clog2(max(count,2)). No counter wraps; each stops at its terminal value.
// STRUCTURE
//  - Package reset_seq_pkg:
//    - state enum (HOLD, SEQ, DONE).
//    - cnt_width(n) function.
//    - parameter-legality checks, as elaborate-time $error on SYNC_DEPTH<2, MIN_HOLD_CYCLES<1, STAGE_GAP_CYCLES<1 or NUM_STAGES<1.
//  - Sub-module reset_sync_bit #(SYNC_DEPTH): one async-clear synchronizer, instantiated once per input bit.
//  - Top level: synchronizer array, trig reduction, FSM, hold_cnt, gap_cnt, stage index, event counter.
// TESTING
//  All scenarios use defaults unless stated.
//  1. Power-up: i_rst=1 for 5 edges, then 0, inputs all 1.
//     -> o_rstn[0] rises at edge 18, [1] at 26, [2] at 34, [3] at 42; o_ready=1 and o_busy=0 at edge 42.
//  2. In DONE, pulse i_rstn_array[0] low for 3 ns within one clock period.
//     -> all o_rstn=0 at the next edge; o_event_cnt=1; re-release follows the timing of scenario 1.
//  3. In SEQ, right after o_rstn[1] rises, assert i_sw_rst_req for 1 cycle.
//     -> o_rstn=0000 next edge; o_event_cnt unchanged; o_rstn[0] rises 16 edges after the request drops.
//  4. NUM_INPUT_RESETS=3, input bits toggled low at staggered times in HOLD.
//     -> hold restarts at each trig; stage 0 releases only after 2+16 clean edges.
//  5. Drive 300 events from DONE with EVENT_CNT_WIDTH=8. -> o_event_cnt saturates at 255.
//  6. NUM_STAGES=1 and STAGE_GAP_CYCLES=1. -> o_rstn[0] and o_ready rise together at edge 18; no X on any output.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package reset_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Legal parameter set for reset_sequencer; the top raises an elaboration error otherwise
    function automatic bit params_ok(input int sync_depth, input int min_hold,
                                     input int stage_gap, input int num_stages);
        return (sync_depth >= 2) && (min_hold >= 1) && (stage_gap >= 1) && (num_stages >= 1);
    endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// Reset synchronizer for one active-low request: async clear, synchronous release.
// Latency: assertion immediate, deassertion visible SYNC_DEPTH edges later.
// Backpressure: none; a low pulse of any width clears the chain.
module reset_sync_bit
    import reset_seq_pkg::*;
#(
    parameter int SYNC_DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rstn_async,
    output logic o_rstn_sync
);

    logic [SYNC_DEPTH-1:0] chain;

    // Shift ones in from the bottom; either reset source clears the whole chain at once
    always_ff @(posedge i_clk or posedge i_rst or negedge i_rstn_async) begin
        if (i_rst) begin
            chain <= '0;
        end else if (!i_rstn_async) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign o_rstn_sync = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges reset requests into one event and releases NUM_STAGES resets in order.
// Latency: request to all-low in one edge; release SYNC_DEPTH+MIN_HOLD_CYCLES edges after clean inputs.
// Backpressure: any new request during HOLD restarts the hold window; during SEQ/DONE it aborts the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_INPUT_RESETS = 1,
    parameter int NUM_STAGES       = 4,
    parameter int SYNC_DEPTH       = 2,
    parameter int MIN_HOLD_CYCLES  = 16,
    parameter int STAGE_GAP_CYCLES = 8,
    parameter int SW_RST_ENABLE    = 1,
    parameter int EVENT_CNT_WIDTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_INPUT_RESETS-1:0] i_rstn_array,
    input  logic                        i_sw_rst_req,
    output logic [NUM_STAGES-1:0]       o_rstn,
    output logic                        o_ready,
    output logic                        o_busy,
    output logic [EVENT_CNT_WIDTH-1:0]  o_event_cnt
);

    if (!params_ok(SYNC_DEPTH, MIN_HOLD_CYCLES, STAGE_GAP_CYCLES, NUM_STAGES)) begin : g_param_check
        $error("reset_sequencer: need SYNC_DEPTH>=2, MIN_HOLD_CYCLES>=1, STAGE_GAP_CYCLES>=1, NUM_STAGES>=1");
    end

    localparam int HOLD_W  = cnt_width(MIN_HOLD_CYCLES);
    localparam int GAP_W   = cnt_width(STAGE_GAP_CYCLES);
    localparam int STAGE_W = cnt_width(NUM_STAGES);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MIN_HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP_CYCLES - 1);
    // Stage index value on the edge that releases the final stage
    localparam int                 STAGE_LAST_I = (NUM_STAGES >= 2) ? NUM_STAGES - 2 : 0;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_LAST_I);

    logic [NUM_INPUT_RESETS-1:0] synced_rstn;
    logic                        sw_trig;
    logic                        trig;

    seq_state_t                 state_q, state_d;
    logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
    logic [STAGE_W-1:0]         stage_q, stage_d;
    logic [NUM_STAGES-1:0]      rstn_q, rstn_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic [EVENT_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

    for (genvar gi = 0; gi < NUM_INPUT_RESETS; gi++) begin : g_sync
        reset_sync_bit #(
            .SYNC_DEPTH (SYNC_DEPTH)
        ) u_sync (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_rstn_async (i_rstn_array[gi]),
            .o_rstn_sync  (synced_rstn[gi])
        );
    end

    assign sw_trig = (SW_RST_ENABLE != 0) && i_sw_rst_req;
    assign trig    = (~&synced_rstn) | sw_trig;

    // Next-state, counters and next output values
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        stage_d    = stage_q;
        rstn_d     = rstn_q;
        evt_cnt_d  = evt_cnt_q;

        case (state_q)
            HOLD: begin
                rstn_d = '0;
                if (trig) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    stage_d    = '0;
                    rstn_d[0]  = 1'b1;
                    state_d    = (NUM_STAGES == 1) ? DONE : SEQ;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            SEQ: begin
                if (trig) begin
                    state_d    = HOLD;
                    rstn_d     = '0;
                    hold_cnt_d = '0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    // Shifting a one in keeps o_rstn thermometer-coded: release order is fixed
                    gap_cnt_d = '0;
                    rstn_d    = NUM_STAGES'({rstn_q, 1'b1});
                    stage_d   = stage_q + 1'b1;
                    if (stage_q == STAGE_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (trig) begin
                    state_d    = HOLD;
                    rstn_d     = '0;
                    hold_cnt_d = '0;
                    if (evt_cnt_q != {EVENT_CNT_WIDTH{1'b1}}) begin
                        evt_cnt_d = evt_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d    = HOLD;
                rstn_d     = '0;
                hold_cnt_d = '0;
            end
        endcase

        ready_d = (state_d == DONE);
        busy_d  = (state_d != DONE);
    end

    // State and registered outputs; reset holds every stage in reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stage_q    <= '0;
            rstn_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            stage_q    <= stage_d;
            rstn_q     <= rstn_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign o_rstn      = rstn_q;
    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign o_event_cnt = evt_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, 3-input and single-stage instances.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_reset_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;

    logic       a_in, a_sw;
    logic [3:0] a_rstn;
    logic       a_ready, a_busy;
    logic [7:0] a_cnt;

    logic [2:0] b_in;
    logic       b_sw;
    logic [3:0] b_rstn;
    logic       b_ready, b_busy;
    logic [7:0] b_cnt;

    logic       c_in, c_sw;
    logic [0:0] c_rstn;
    logic       c_ready, c_busy;
    logic [7:0] c_cnt;

    int n_vec = 0;
    int n_err = 0;
    int ecnt  = 0;

    always #5 i_clk = ~i_clk;

    reset_sequencer u_dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_rstn_array(a_in), .i_sw_rst_req(a_sw),
        .o_rstn(a_rstn), .o_ready(a_ready), .o_busy(a_busy), .o_event_cnt(a_cnt)
    );

    reset_sequencer #(.NUM_INPUT_RESETS(3)) u_dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_rstn_array(b_in), .i_sw_rst_req(b_sw),
        .o_rstn(b_rstn), .o_ready(b_ready), .o_busy(b_busy), .o_event_cnt(b_cnt)
    );

    reset_sequencer #(.NUM_STAGES(1), .STAGE_GAP_CYCLES(1)) u_dut_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_rstn_array(c_in), .i_sw_rst_req(c_sw),
        .o_rstn(c_rstn), .o_ready(c_ready), .o_busy(c_busy), .o_event_cnt(c_cnt)
    );

    typedef struct {
        int         edge_n;
        logic [3:0] a_rstn;
        logic       a_rdy;
        logic       a_bsy;
        logic       c_rstn;
        logic       c_rdy;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge i_clk);
        #1;
        ecnt++;
    endtask

    task automatic step_to(input int target);
        while (ecnt < target) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    // Low pulse of 3 ns placed inside one clock period, clear of both edges
    task automatic pulse_a();
        #2 a_in = 1'b0;
        #3 a_in = 1'b1;
    endtask

    task automatic pulse_b(input int idx);
        #2 b_in[idx] = 1'b0;
        #3 b_in[idx] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_cnt;
        int guard;

        // Power-up release timing (edge numbers counted from reset deassertion)
        tbl[0] = '{1,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{17, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{18, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{25, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{26, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{33, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{34, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{41, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{42, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{45, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1};

        i_rst = 1'b1;
        a_in = 1'b1; a_sw = 1'b0;
        b_in = 3'b111; b_sw = 1'b0;
        c_in = 1'b1; c_sw = 1'b0;

        repeat (5) @(posedge i_clk);
        #1;
        chk("rst_a_rstn",  a_rstn,  0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_busy",  a_busy,  1);
        chk("rst_a_cnt",   a_cnt,   0);
        chk("rst_c_rstn",  c_rstn,  0);
        chk("rst_c_busy",  c_busy,  1);
        i_rst = 1'b0;
        ecnt  = 0;

        // Scenario 1 + 6: table-driven power-up sequence
        for (int i = 0; i < 10; i++) begin
            step_to(tbl[i].edge_n);
            chk("pu_a_rstn",  a_rstn,  tbl[i].a_rstn);
            chk("pu_a_ready", a_ready, tbl[i].a_rdy);
            chk("pu_a_busy",  a_busy,  tbl[i].a_bsy);
            chk("pu_b_rstn",  b_rstn,  tbl[i].a_rstn);
            chk("pu_c_rstn",  c_rstn,  tbl[i].c_rstn);
            chk("pu_c_ready", c_ready, tbl[i].c_rdy);
            chk("pu_c_busy",  c_busy,  !tbl[i].c_rdy);
        end

        // Scenario 2: short async pulse while DONE
        base = ecnt;
        pulse_a();
        step();
        chk("s2_rstn_low", a_rstn, 4'b0000);
        chk("s2_cnt",      a_cnt,  1);
        chk("s2_busy",     a_busy, 1);
        chk("s2_ready",    a_ready, 0);
        step_to(base + 17); chk("s2_rstn_e17", a_rstn, 4'b0000);
        step_to(base + 18); chk("s2_rstn_e18", a_rstn, 4'b0001);
        step_to(base + 41); chk("s2_rstn_e41", a_rstn, 4'b0111);
        chk("s2_ready_e41", a_ready, 0);
        step_to(base + 42); chk("s2_rstn_e42", a_rstn, 4'b1111);
        chk("s2_ready_e42", a_ready, 1);
        chk("s2_busy_e42",  a_busy, 0);

        // Scenario 3: software request from DONE, then again mid-SEQ
        base = ecnt;
        a_sw = 1'b1;
        step();
        a_sw = 1'b0;
        chk("s3_done_rstn", a_rstn, 4'b0000);
        chk("s3_done_cnt",  a_cnt,  2);
        step_to(base + 16); chk("s3_rstn_e16", a_rstn, 4'b0000);
        step_to(base + 17); chk("s3_rstn_e17", a_rstn, 4'b0001);
        step_to(base + 25); chk("s3_rstn_e25", a_rstn, 4'b0011);
        a_sw = 1'b1;
        step();
        a_sw = 1'b0;
        chk("s3_seq_rstn", a_rstn, 4'b0000);
        chk("s3_seq_cnt",  a_cnt,  2);
        chk("s3_seq_busy", a_busy, 1);
        step_to(base + 41); chk("s3_rstn_e41", a_rstn, 4'b0000);
        step_to(base + 42); chk("s3_rstn_e42", a_rstn, 4'b0001);
        step_to(base + 66); chk("s3_rstn_e66", a_rstn, 4'b1111);
        chk("s3_ready_e66", a_ready, 1);

        // Scenario 4: staggered input pulses on the 3-input instance
        base = ecnt;
        pulse_b(0);
        step();
        chk("s4_rstn_low", b_rstn, 4'b0000);
        chk("s4_cnt",      b_cnt,  1);
        step_to(base + 4);
        pulse_b(1);
        step_to(base + 8);
        pulse_b(2);
        step_to(base + 18); chk("s4_rstn_e18", b_rstn, 4'b0000);
        step_to(base + 22); chk("s4_rstn_e22", b_rstn, 4'b0000);
        step_to(base + 25); chk("s4_rstn_e25", b_rstn, 4'b0000);
        step_to(base + 26); chk("s4_rstn_e26", b_rstn, 4'b0001);
        chk("s4_cnt_after", b_cnt, 1);

        // Continuous request keeps the single-stage instance in HOLD
        base = ecnt;
        c_in = 1'b0;
        step();
        chk("hold_c_rstn", c_rstn, 0);
        chk("hold_c_ready", c_ready, 0);
        chk("hold_c_cnt", c_cnt, 1);
        step_to(base + 40);
        chk("hold_c_rstn_e40", c_rstn, 0);
        chk("hold_c_busy_e40", c_busy, 1);
        c_in = 1'b1;
        step_to(base + 57); chk("hold_c_rstn_e57", c_rstn, 0);
        step_to(base + 58); chk("hold_c_rstn_e58", c_rstn, 1);
        chk("hold_c_ready_e58", c_ready, 1);
        chk("hold_c_busy_e58", c_busy, 0);

        // Scenario 5: 300 events from DONE, counter saturates
        exp_cnt = 2;
        for (int e = 0; e < 300; e++) begin
            guard = 0;
            while (!a_ready && guard < 200) begin
                step();
                guard++;
            end
            if (!a_ready) begin
                chk("s5_ready_timeout", a_ready, 1);
                break;
            end
            a_sw = 1'b1;
            step();
            a_sw = 1'b0;
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            chk("s5_cnt", a_cnt, exp_cnt);
        end
        chk("s5_cnt_final", a_cnt, 255);
        chk("s5_rstn_final", a_rstn, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
